// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Holds the fetch FSM state encoding, the default reset PC and the
// {pc, instr} payload stored in each queue entry.
package ifetch_queue_pkg;

    localparam int unsigned XLEN = 32;

    // Default first fetch address after reset.
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // IDLE: no request; REQ: live fetch at fetch_pc; DISCARD: stale fetch whose data is dropped.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    // One buffered instruction with its fetch address.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// fetch_fifo: circular buffer of DEPTH {pc, instr} entries.
// Ports: clk, rst (sync, active-low), flush_i (clears everything, wins over
// push/pop), push_i/data_i (write tail), pop_i (advance head), count_o,
// valid_o (head present), head_o (head entry, zero when empty).
module fetch_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  fetch_entry_t            data_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    valid_o,
    output fetch_entry_t            head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Pointer/count update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop_i) begin
                head_d = head_q + AW'(1);
            end
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[tail_q] <= data_i;
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[head_q] : '0;

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction prefetcher feeding the decode stage.
// Ports: clk, rst (sync, active-low); redirect_i/redirect_pc_i (flush and
// refetch from target); stall_i (hold head); imem_req_o/imem_addr_o/
// imem_ack_i/imem_rdata_i (memory handshake); valid_o/instr_o/pc_o (head).
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam int unsigned    CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   stale_pc_q, stale_pc_d;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    logic          fifo_valid;
    logic          push;
    logic          pop;
    logic          has_room;
    fetch_entry_t  head;

    assign pop      = fifo_valid && !stall_i && !redirect_i;
    assign push     = (state_q == ST_REQ) && imem_ack_i && !redirect_i;
    assign count_nx = count + CW'(push) - CW'(pop);
    // Only issue when the word can be stored next cycle, so a push never overflows.
    assign has_room = (count_nx < DEPTH_C);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ('{pc: fetch_pc_q, instr: imem_rdata_i}),
        .count_o (count),
        .valid_o (fifo_valid),
        .head_o  (head)
    );

    // Fetch FSM next state and fetch_pc update.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        stale_pc_d = stale_pc_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
        end
        case (state_q)
            ST_IDLE: begin
                if (redirect_i || has_room) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect_i) begin
                    // Without ack the request must be held at its old address.
                    if (!imem_ack_i) begin
                        state_d    = ST_DISCARD;
                        stale_pc_d = fetch_pc_q;
                    end
                end else if (imem_ack_i) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = has_room ? ST_REQ : ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (imem_ack_i) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            stale_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            stale_pc_q <= stale_pc_d;
        end
    end

    // Memory-side outputs decoded from state and registered addresses only.
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = '0;
        case (state_q)
            ST_REQ: begin
                imem_req_o  = 1'b1;
                imem_addr_o = fetch_pc_q;
            end
            ST_DISCARD: begin
                imem_req_o  = 1'b1;
                imem_addr_o = stale_pc_q;
            end
            default: begin
                imem_req_o  = 1'b0;
                imem_addr_o = '0;
            end
        endcase
    end

    assign valid_o = fifo_valid;
    assign instr_o = head.instr;
    assign pc_o    = head.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_ifetch_queue;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: buffered {pc, instr} words plus the one outstanding request.
    logic [63:0] m_q[$];
    logic [31:0] m_fpc   = RST_PC;
    logic [31:0] m_oaddr = '0;
    bit          m_busy  = 1'b0;
    bit          m_stale = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0BAD_F00D;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pop;
        if (!rst) begin
            m_q.delete();
            m_fpc   = RST_PC;
            m_busy  = 1'b0;
            m_stale = 1'b0;
            m_oaddr = '0;
        end else if (redirect_i) begin
            m_q.delete();
            m_fpc = redirect_pc_i;
            if (m_busy && !imem_ack_i) begin
                m_stale = 1'b1;
            end else begin
                m_busy  = 1'b1;
                m_stale = 1'b0;
                m_oaddr = m_fpc;
            end
        end else begin
            pop = (m_q.size() > 0) && !stall_i;
            if (pop) void'(m_q.pop_front());
            if (m_busy && imem_ack_i) begin
                if (!m_stale) begin
                    m_q.push_back({m_oaddr, imem_rdata_i});
                    m_fpc = m_fpc + 32'd4;
                end
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end
            if (!m_busy && (m_q.size() < DEPTH)) begin
                m_busy  = 1'b1;
                m_oaddr = m_fpc;
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 64'd0;
        check32("req",   {31'd0, imem_req_o}, {31'd0, m_busy});
        check32("addr",  imem_addr_o, m_busy ? m_oaddr : 32'd0);
        check32("valid", {31'd0, valid_o}, {31'd0, (m_q.size() > 0)});
        check32("pc",    pc_o,    h[63:32]);
        check32("instr", instr_o, h[31:0]);
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        imem_rdata_i = mem_word(imem_addr_o);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        imem_ack_i = 1'b0;
        tick();
        check32("rst_req",   {31'd0, imem_req_o}, 32'd0);
        check32("rst_addr",  imem_addr_o, 32'd0);
        check32("rst_valid", {31'd0, valid_o}, 32'd0);
        check32("rst_pc",    pc_o, 32'd0);
        check32("rst_instr", instr_o, 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        rst           = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        stall_i       = 1'b0;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = '0;
        tick();

        // Zero-wait memory: one fetch per cycle, output one cycle after ack.
        do_reset();
        imem_ack_i = 1'b1;
        tick();
        check32("zw_req0",  {31'd0, imem_req_o}, 32'd1);
        check32("zw_addr0", imem_addr_o, 32'h0);
        check32("zw_val0",  {31'd0, valid_o}, 32'd0);
        tick();
        check32("zw_addr1", imem_addr_o, 32'h4);
        check32("zw_pc0",   pc_o, 32'h0);
        check32("zw_ins0",  instr_o, mem_word(32'h0));
        tick();
        check32("zw_addr2", imem_addr_o, 32'h8);
        check32("zw_pc1",   pc_o, 32'h4);
        repeat (20) tick();

        // Stalled decode fills the queue, then drains gap-free.
        do_reset();
        stall_i    = 1'b1;
        imem_ack_i = 1'b1;
        repeat (6) tick();
        check32("full_req", {31'd0, imem_req_o}, 32'd0);
        check32("full_val", {31'd0, valid_o}, 32'd1);
        check32("full_pc",  pc_o, 32'h0);
        stall_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check32("drain_val", {31'd0, valid_o}, 32'd1);
            check32("drain_pc",  pc_o, 32'(4 * k));
        end

        // Redirect during a slow ack: stale data dropped, refetch at target.
        do_reset();
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        tick();
        redirect_i = 1'b0;
        check32("dis_req",   {31'd0, imem_req_o}, 32'd1);
        check32("dis_addr",  imem_addr_o, 32'h0);
        tick();
        check32("dis_addr2", imem_addr_o, 32'h0);
        imem_ack_i = 1'b1;
        tick();
        check32("dis_new",   imem_addr_o, 32'h100);
        check32("dis_val",   {31'd0, valid_o}, 32'd0);
        tick();
        check32("dis_pc",    pc_o, 32'h100);
        check32("dis_ins",   instr_o, mem_word(32'h100));

        // Redirect coincident with ack while entries are buffered.
        do_reset();
        stall_i    = 1'b1;
        imem_ack_i = 1'b1;
        repeat (4) tick();
        check32("ra_addr", imem_addr_o, 32'hC);
        check32("ra_pc",   pc_o, 32'h0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        tick();
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        check32("ra_val0", {31'd0, valid_o}, 32'd0);
        check32("ra_new",  imem_addr_o, 32'h200);
        tick();
        check32("ra_pc1",  pc_o, 32'h200);

        // Two redirects while discarding: only the latest target is fetched.
        do_reset();
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h300;
        tick();
        redirect_pc_i = 32'h400;
        tick();
        redirect_i = 1'b0;
        check32("rr_stale", imem_addr_o, 32'h0);
        imem_ack_i = 1'b1;
        tick();
        check32("rr_new",   imem_addr_o, 32'h400);
        tick();
        check32("rr_pc",    pc_o, 32'h400);
        check32("rr_val",   {31'd0, valid_o}, 32'd1);

        // Reset while a request is outstanding with two entries queued.
        do_reset();
        stall_i    = 1'b1;
        imem_ack_i = 1'b1;
        repeat (3) tick();
        imem_ack_i = 1'b0;
        tick();
        check32("mr_addr", imem_addr_o, 32'h8);
        rst = 1'b0;
        tick();
        check32("mr_val", {31'd0, valid_o}, 32'd0);
        check32("mr_req", {31'd0, imem_req_o}, 32'd0);
        rst        = 1'b1;
        imem_ack_i = 1'b1;
        stall_i    = 1'b0;
        tick();
        check32("mr_restart", imem_addr_o, RST_PC);

        // Randomized traffic; last third uses an always-ready memory.
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 299) != 0);
            redirect_i    = ($urandom_range(0, 15) == 0);
            redirect_pc_i = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            stall_i       = (((i / 500) % 2) == 1) ? ($urandom_range(0, 3) == 0)
                                                   : ($urandom_range(0, 1) == 0);
            imem_ack_i    = (i >= 2000) ? 1'b1 : (imem_req_o && ($urandom_range(0, 2) != 0));
            imem_rdata_i  = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
